alu_arbiter: RTL and testbench

- Shares one combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/auxiliary unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, drives the shared ALU operand and opcode lines for the granted requester, and captures result plus Z/N/V flags into that requester's one-entry response buffer.
- Sits between the requesters and the ALU instance; the ALU operand mux stays upstream in each requester.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Port 0 is the execute stage and port 1 is the address/auxiliary unit.
// Each port has a one-entry response buffer that captures the ALU result and
// Z/N/V flags on the edge that ends its grant cycle.
module alu_arbiter #(
   parameter int               WIDTH    = 32,
   parameter int               FOP_W    = 4,
   parameter logic [FOP_W-1:0] IDLE_FOP = FOP_W'(15)
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_rda,
   input  logic [WIDTH-1:0] req0_rdb,
   input  logic [FOP_W-1:0] req0_fop,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_z,
   output logic             rsp0_n,
   output logic             rsp0_v,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_rda,
   input  logic [WIDTH-1:0] req1_rdb,
   input  logic [FOP_W-1:0] req1_fop,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_z,
   output logic             rsp1_n,
   output logic             rsp1_v,

   output logic [WIDTH-1:0] alu_rda,
   output logic [WIDTH-1:0] alu_rdb,
   output logic [FOP_W-1:0] alu_fop,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_v
);

   // last_grant_q = 1 means port 1 was granted most recently, so port 0 wins a tie.
   logic             last_grant_q, last_grant_d;

   logic             rsp0_valid_q, rsp0_valid_d;
   logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
   logic             rsp0_z_q, rsp0_z_d;
   logic             rsp0_n_q, rsp0_n_d;
   logic             rsp0_v_q, rsp0_v_d;

   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
   logic             rsp1_z_q, rsp1_z_d;
   logic             rsp1_n_q, rsp1_n_d;
   logic             rsp1_v_q, rsp1_v_d;

   logic             elig0, elig1;
   logic             grant0, grant1;

   // A port may be granted only if its buffer is empty or drains on this edge,
   // so a stalled response never blocks the other port.
   assign elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
   assign elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);

   // Grants are suppressed during reset so readies read 0 while rst is high.
   assign grant0 = ~rst & elig0 & (~elig1 | last_grant_q);
   assign grant1 = ~rst & elig1 & (~elig0 | ~last_grant_q);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign rsp0_valid  = rsp0_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_z      = rsp0_z_q;
   assign rsp0_n      = rsp0_n_q;
   assign rsp0_v      = rsp0_v_q;

   assign rsp1_valid  = rsp1_valid_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_z      = rsp1_z_q;
   assign rsp1_n      = rsp1_n_q;
   assign rsp1_v      = rsp1_v_q;

   // Drive the shared ALU from the granted port; park it on zeros and the idle opcode otherwise.
   always_comb begin
      alu_rda = '0;
      alu_rdb = '0;
      alu_fop = IDLE_FOP;
      if (grant0) begin
         alu_rda = req0_rda;
         alu_rdb = req0_rdb;
         alu_fop = req0_fop;
      end else if (grant1) begin
         alu_rda = req1_rda;
         alu_rdb = req1_rdb;
         alu_fop = req1_fop;
      end
   end

   // Next state: capture on grant takes priority over draining the buffer.
   always_comb begin
      last_grant_d  = last_grant_q;
      rsp0_valid_d  = rsp0_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp0_z_d      = rsp0_z_q;
      rsp0_n_d      = rsp0_n_q;
      rsp0_v_d      = rsp0_v_q;
      rsp1_valid_d  = rsp1_valid_q;
      rsp1_result_d = rsp1_result_q;
      rsp1_z_d      = rsp1_z_q;
      rsp1_n_d      = rsp1_n_q;
      rsp1_v_d      = rsp1_v_q;

      if (grant0) begin
         last_grant_d = 1'b0;
      end else if (grant1) begin
         last_grant_d = 1'b1;
      end

      if (grant0) begin
         rsp0_valid_d  = 1'b1;
         rsp0_result_d = alu_result;
         rsp0_z_d      = alu_z;
         rsp0_n_d      = alu_n;
         rsp0_v_d      = alu_v;
      end else if (rsp0_valid_q && rsp0_ready) begin
         rsp0_valid_d = 1'b0;
      end

      if (grant1) begin
         rsp1_valid_d  = 1'b1;
         rsp1_result_d = alu_result;
         rsp1_z_d      = alu_z;
         rsp1_n_d      = alu_n;
         rsp1_v_d      = alu_v;
      end else if (rsp1_valid_q && rsp1_ready) begin
         rsp1_valid_d = 1'b0;
      end
   end

   // State registers; reset empties both buffers and lets port 0 win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q  <= 1'b1;
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_z_q      <= 1'b0;
         rsp0_n_q      <= 1'b0;
         rsp0_v_q      <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_z_q      <= 1'b0;
         rsp1_n_q      <= 1'b0;
         rsp1_v_q      <= 1'b0;
      end else begin
         last_grant_q  <= last_grant_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_z_q      <= rsp0_z_d;
         rsp0_n_q      <= rsp0_n_d;
         rsp0_v_q      <= rsp0_v_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_z_q      <= rsp1_z_d;
         rsp1_n_q      <= rsp1_n_d;
         rsp1_v_q      <= rsp1_v_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ADD/SUB ALU attached to the shared port.
module tb_alu_arbiter;

   localparam int WIDTH = 32;
   localparam int FOP_W = 4;

   logic             clk;
   logic             rst;
   logic             req0_valid, req0_ready;
   logic [WIDTH-1:0] req0_rda, req0_rdb;
   logic [FOP_W-1:0] req0_fop;
   logic             rsp0_valid, rsp0_ready;
   logic [WIDTH-1:0] rsp0_result;
   logic             rsp0_z, rsp0_n, rsp0_v;
   logic             req1_valid, req1_ready;
   logic [WIDTH-1:0] req1_rda, req1_rdb;
   logic [FOP_W-1:0] req1_fop;
   logic             rsp1_valid, rsp1_ready;
   logic [WIDTH-1:0] rsp1_result;
   logic             rsp1_z, rsp1_n, rsp1_v;
   logic [WIDTH-1:0] alu_rda, alu_rdb, alu_result;
   logic [FOP_W-1:0] alu_fop;
   logic             alu_z, alu_n, alu_v;

   int n_vec;
   int n_err;

   alu_arbiter #(.WIDTH(WIDTH), .FOP_W(FOP_W), .IDLE_FOP(4'd15)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rda(req0_rda),
      .req0_rdb(req0_rdb), .req0_fop(req0_fop),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_z(rsp0_z), .rsp0_n(rsp0_n), .rsp0_v(rsp0_v),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rda(req1_rda),
      .req1_rdb(req1_rdb), .req1_fop(req1_fop),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_z(rsp1_z), .rsp1_n(rsp1_n), .rsp1_v(rsp1_v),
      .alu_rda(alu_rda), .alu_rdb(alu_rdb), .alu_fop(alu_fop),
      .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: fop 0 = ADD, fop 1 = SUB, anything else yields 0 with clear flags.
   always_comb begin
      alu_result = '0;
      alu_z      = 1'b0;
      alu_n      = 1'b0;
      alu_v      = 1'b0;
      if (alu_fop == 4'd0) begin
         alu_result = alu_rda + alu_rdb;
         alu_v = (alu_rda[WIDTH-1] == alu_rdb[WIDTH-1]) && (alu_result[WIDTH-1] != alu_rda[WIDTH-1]);
         alu_z = (alu_result == '0);
         alu_n = alu_result[WIDTH-1];
      end else if (alu_fop == 4'd1) begin
         alu_result = alu_rda - alu_rdb;
         alu_v = (alu_rda[WIDTH-1] != alu_rdb[WIDTH-1]) && (alu_result[WIDTH-1] != alu_rda[WIDTH-1]);
         alu_z = (alu_result == '0);
         alu_n = alu_result[WIDTH-1];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req0_valid = 1'b0; req0_rda = '0; req0_rdb = '0; req0_fop = '0;
      req1_valid = 1'b0; req1_rda = '0; req1_rdb = '0; req1_fop = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_reqs();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      tick();
      tick();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         n_err++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
      end
      n_vec++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         n_err++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid});
      end
      n_vec++;
      if ({rsp0_result, rsp0_z, rsp0_n, rsp0_v, rsp1_result, rsp1_z, rsp1_n, rsp1_v} !== '0) begin
         n_err++; $display("FAIL reset_rsp_data got %h/%h want 0/0", rsp0_result, rsp1_result);
      end
      n_vec++;
      if ({alu_fop, alu_rda, alu_rdb} !== {4'd15, 64'd0}) begin
         n_err++; $display("FAIL reset_alu_idle got fop=%0d a=%h b=%h want fop=15 a=0 b=0", alu_fop, alu_rda, alu_rdb);
      end
      clear_reqs();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_rda = 32'd5; req0_rdb = 32'd7; req0_fop = 4'd0;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++; $display("FAIL single_ready got %b want 1", req0_ready);
      end
      n_vec++;
      if ({alu_fop, alu_rda, alu_rdb} !== {4'd0, 32'd5, 32'd7}) begin
         n_err++; $display("FAIL single_alu_drive got fop=%0d a=%0d b=%0d want 0/5/7", alu_fop, alu_rda, alu_rdb);
      end
      tick();
      clear_reqs();
      n_vec++;
      if ({rsp0_valid, rsp0_result, rsp0_z, rsp0_n, rsp0_v} !== {1'b1, 32'd12, 3'b000}) begin
         n_err++; $display("FAIL single_rsp got v=%b r=%0d zn v=%b%b%b want v=1 r=12 znv=000",
                           rsp0_valid, rsp0_result, rsp0_z, rsp0_n, rsp0_v);
      end
      tick();
      n_vec++;
      if (rsp0_valid !== 1'b0) begin
         n_err++; $display("FAIL single_drain got %b want 0", rsp0_valid);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      req0_valid = 1'b1; req0_rda = 32'd1;  req0_rdb = 32'd2; req0_fop = 4'd0;
      req1_valid = 1'b1; req1_rda = 32'd10; req1_rdb = 32'd4; req1_fop = 4'd1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_vec++;
         if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_err++; $display("FAIL alt_grant c=%0d got %b want %b", c, {req0_ready, req1_ready},
                              (c % 2 == 0) ? 2'b10 : 2'b01);
         end
         tick();
         n_vec++;
         if ({rsp0_valid, rsp1_valid} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_err++; $display("FAIL alt_rsp_valid c=%0d got %b want %b", c, {rsp0_valid, rsp1_valid},
                              (c % 2 == 0) ? 2'b10 : 2'b01);
         end
         n_vec++;
         if (((c % 2 == 0) ? rsp0_result : rsp1_result) !== ((c % 2 == 0) ? 32'd3 : 32'd6)) begin
            n_err++; $display("FAIL alt_result c=%0d got %0d want %0d", c,
                              (c % 2 == 0) ? rsp0_result : rsp1_result, (c % 2 == 0) ? 3 : 6);
         end
      end
      clear_reqs();
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_rda = 32'd20; req0_rdb = 32'd22; req0_fop = 4'd0;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_first_grant got %b want 1", req0_ready);
      end
      tick();
      n_vec++;
      if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd42}) begin
         n_err++; $display("FAIL bp_first_rsp got v=%b r=%0d want v=1 r=42", rsp0_valid, rsp0_result);
      end
      req0_rda = 32'd1; req0_rdb = 32'd1;
      req1_valid = 1'b1; req1_fop = 4'd0;
      for (int c = 0; c < 3; c++) begin
         req1_rda = 32'd100 + 32'(c);
         req1_rdb = 32'(c);
         #1;
         n_vec++;
         if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_grant c=%0d got %b want 01", c, {req0_ready, req1_ready});
         end
         tick();
         n_vec++;
         if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd42}) begin
            n_err++; $display("FAIL bp_hold c=%0d got v=%b r=%0d want v=1 r=42", c, rsp0_valid, rsp0_result);
         end
         n_vec++;
         if ({rsp1_valid, rsp1_result} !== {1'b1, 32'd100 + 32'(2 * c)}) begin
            n_err++; $display("FAIL bp_port1 c=%0d got v=%b r=%0d want v=1 r=%0d", c, rsp1_valid,
                              rsp1_result, 100 + 2 * c);
         end
      end
      rsp0_ready = 1'b1;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++; $display("FAIL bp_release_grant got %b want 10", {req0_ready, req1_ready});
      end
      tick();
      clear_reqs();
      n_vec++;
      if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd2}) begin
         n_err++; $display("FAIL bp_release_rsp got v=%b r=%0d want v=1 r=2", rsp0_valid, rsp0_result);
      end
      tick();
   endtask

   task automatic test_flags();
      req1_valid = 1'b1; req1_rda = 32'h7FFF_FFFF; req1_rdb = 32'd1; req1_fop = 4'd0;
      tick();
      n_vec++;
      if ({rsp1_valid, rsp1_result, rsp1_z, rsp1_n, rsp1_v} !== {1'b1, 32'h8000_0000, 3'b011}) begin
         n_err++; $display("FAIL flags_overflow got v=%b r=%h znv=%b%b%b want v=1 r=80000000 znv=011",
                           rsp1_valid, rsp1_result, rsp1_z, rsp1_n, rsp1_v);
      end
      req1_rda = 32'd9; req1_rdb = 32'd9; req1_fop = 4'd1;
      tick();
      clear_reqs();
      n_vec++;
      if ({rsp1_valid, rsp1_result, rsp1_z, rsp1_n, rsp1_v} !== {1'b1, 32'd0, 3'b100}) begin
         n_err++; $display("FAIL flags_zero got v=%b r=%h znv=%b%b%b want v=1 r=0 znv=100",
                           rsp1_valid, rsp1_result, rsp1_z, rsp1_n, rsp1_v);
      end
      tick();
   endtask

   task automatic test_idle();
      clear_reqs();
      tick();
      tick();
      n_vec++;
      if ({alu_fop, alu_rda, alu_rdb} !== {4'd15, 64'd0}) begin
         n_err++; $display("FAIL idle_alu got fop=%0d a=%h b=%h want fop=15 a=0 b=0", alu_fop, alu_rda, alu_rdb);
      end
      n_vec++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         n_err++; $display("FAIL idle_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid});
      end
   endtask

   task automatic test_reset_mid();
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_rda = 32'd3; req0_rdb = 32'd4; req0_fop = 4'd0;
      tick();
      req0_valid = 1'b0;
      n_vec++;
      if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd7}) begin
         n_err++; $display("FAIL rstmid_pre got v=%b r=%0d want v=1 r=7", rsp0_valid, rsp0_result);
      end
      rst = 1'b1;
      tick();
      n_vec++;
      if ({rsp0_valid, rsp0_result} !== {1'b0, 32'd0}) begin
         n_err++; $display("FAIL rstmid_flush got v=%b r=%0d want v=0 r=0", rsp0_valid, rsp0_result);
      end
      rst = 1'b0;
      rsp0_ready = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1; req1_fop = 4'd0;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_err++; $display("FAIL rstmid_tie got %b want 10", {req0_ready, req1_ready});
      end
      tick();
      clear_reqs();
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      clear_reqs();
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_flags();
      test_idle();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
